gate_result_collector: RTL and testbench
========================================

// Module: gate_result_collector
// PURPOSE
//   Downstream stage of the basicgates 1-bit unit in the ALU_trail datapath.
//   - Consumes the 7 gate outputs (y1..y7) once per accepted beat.
//   - Selects one output by opcode and assembles WIDTH serial result bits,
//     LSB first, into a parallel word.
//   - Hands the word and its popcount downstream over a valid/ready handshake.
// PARAMETERS
//   WIDTH   8   number of 1-bit results assembled per word (>=2)
//   CNTW    4   counter/popcount width; must equal $clog2(WIDTH+1)
// PORTS
//   clk         in   1      single clock; all state updates on rising edge
//   rst         in   1      synchronous reset, active-high
//   start       in   1      begin a new word (honoured in IDLE, or in HOLD with handshake)
//   in_valid    in   1      y/op beat valid
//   in_ready    out  1      collector accepts a beat this cycle
//   op          in   3      gate select: 0=y1 AND,1=y2 OR,2=y3 NOT a,3=y4 NAND,4=y5 NOR,5=y6 XOR,6=y7 XNOR,7=illegal
//   y           in   7      gate outputs, y[0]=y1 ... y[6]=y7
//   busy        out  1      1 in COLLECT
//   out_valid   out  1      assembled word available
//   out_ready   in   1      downstream takes word
//   out_word    out  WIDTH  assembled result, bit i = i-th accepted beat
//   ones_count  out  CNTW   number of 1s in out_word
//   op_err      out  1      sticky: an illegal op was accepted in current word
// BEHAVIOUR
//   Reset (rst=1 at an edge; overrides everything, incl. mid-word):
//     - state=IDLE.
//     - in_ready=0, busy=0, out_valid=0.
//     - out_word=0, ones_count=0, op_err=0, beat index=0.
//   States: IDLE, COLLECT, HOLD (all outputs registered).
//   IDLE:
//     - in_ready=0.
//     - start=1 -> COLLECT next cycle; clears index, out_word, ones_count, op_err.
//   COLLECT:
//     - in_ready=1, busy=1.
//     - Beat accepted iff in_valid & in_ready: bit = (op==7) ? 0 : y[op].
//     - Bit is written to out_word[index]; ones_count += bit; index += 1.
//     - op==7 accepted -> op_err=1; op_err holds until the next word start.
//     - in_valid=0 -> no state change (bubbles allowed, no timeout).
//     - start ignored.
//     - Accepting beat index WIDTH-1 -> HOLD next cycle; in_ready drops the
//       same edge, so no beat WIDTH+1 is accepted.
//   HOLD:
//     - out_valid=1, in_ready=0, busy=0.
//     - out_word, ones_count, op_err stable until the handshake.
//     - out_valid & out_ready -> IDLE; with start=1 in the same cycle -> COLLECT
//       directly with cleared word (back-to-back words, 1-cycle gap).
//     - out_ready while not out_valid -> no effect.
//   Latency:
//     - Last beat accepted at edge N -> out_valid=1 after edge N.
//     - Word consumed at edge M -> out_valid=0 after edge M.
//   Widths:
//     - index and ones_count use CNTW bits; no wrap (max value WIDTH).
//     - ones_count never exceeds WIDTH.
// TESTING (WIDTH=8)
//   1. Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, state IDLE.
//   2. XOR word: start, then op=5 for 8 beats with y6 = 1,0,1,1,0,0,1,0
//      -> out_word=8'h4D, ones_count=4, op_err=0.
//   3. Bubbles/backpressure: same data with in_valid low every other cycle and
//      out_ready held 0 for 5 cycles -> word unchanged, out_valid held, in_ready=0 in HOLD.
//   4. Illegal op: beat 3 uses op=7 with y=7'h7F, other beats op=0 and y=7'h7F
//      -> out_word=8'hF7, ones_count=7, op_err=1; op_err clears on next start.
//   5. Back-to-back: out_ready=1 and start=1 in the same HOLD cycle -> COLLECT
//      next cycle, out_word=0, first new beat lands in bit 0.
//   6. Reset mid-word: rst after 4 beats -> IDLE, all 0; a fresh word of 8 beats
//      of op=1 with y=7'h02 -> out_word=8'hFF, ones_count=8.

Source files
------------

// File: rtl/gate_result_collector.sv
// gate_result_collector
//   Collects WIDTH serial 1-bit gate results from the basicgates unit into a
//   parallel word, LSB first. Each accepted beat selects one gate output by
//   opcode. The finished word and its popcount are offered downstream over a
//   valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   start       begin a new word (IDLE, or HOLD together with the handshake)
//   in_valid    beat (op/y) valid
//   in_ready    collector accepts a beat this cycle
//   op          gate select 0..6 -> y[0]..y[6]; 7 is illegal and yields bit 0
//   y           gate outputs, y[0]=y1 ... y[6]=y7
//   busy        high while collecting
//   out_valid   assembled word available
//   out_ready   downstream takes the word
//   out_word    assembled word, bit i = i-th accepted beat
//   ones_count  number of ones in out_word
//   op_err      sticky flag: an illegal op was accepted in the current word
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; last word's outputs remain visible
// COLLECT | accepting beats until WIDTH bits have been assembled
// HOLD    | word offered downstream; waits for out_ready
module gate_result_collector #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [6:0]       y,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [CNTW-1:0]  ones_count,
  output logic             op_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CNTW-1:0]  ones_q, ones_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  logic [7:0] y_ext;
  logic       bit_in;
  logic       beat;
  logic       last_beat;

  // y_ext[7] is tied low so op==7 naturally selects a 0 bit.
  assign y_ext     = {1'b0, y};
  assign bit_in    = y_ext[op];
  assign beat      = in_valid & in_ready_q;
  assign last_beat = (idx_q == CNTW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    ones_d  = ones_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          idx_d   = '0;
          word_d  = '0;
          ones_d  = '0;
          err_d   = 1'b0;
        end
      end

      COLLECT: begin
        if (beat) begin
          // Compare-and-write per bit so the CNTW-wide index never has to
          // select directly into the narrower word.
          for (int i = 0; i < WIDTH; i++) begin
            if (idx_q == CNTW'(i)) word_d[i] = bit_in;
          end
          ones_d = ones_q + {{(CNTW-1){1'b0}}, bit_in};
          idx_d  = idx_q + {{(CNTW-1){1'b0}}, 1'b1};
          if (op == 3'd7) err_d = 1'b1;
          if (last_beat) state_d = HOLD;
        end
      end

      HOLD: begin
        // out_valid is always high in HOLD, so out_ready alone completes it.
        if (out_ready) begin
          if (start) begin
            state_d = COLLECT;
            idx_d   = '0;
            word_d  = '0;
            ones_d  = '0;
            err_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state so they change on
    // the same edge as the state itself.
    in_ready_d  = (state_d == COLLECT);
    busy_d      = (state_d == COLLECT);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      ones_q      <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      ones_q      <= ones_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_word   = word_q;
  assign ones_count = ones_q;
  assign op_err     = err_q;

endmodule

// File: tb/tb_gate_result_collector.sv
module tb_gate_result_collector;

  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [6:0]       y;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [CNTW-1:0]  ones_count;
  logic             op_err;

  int n_checks = 0;
  int n_errors = 0;

  gate_result_collector #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .y          (y),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .ones_count (ones_count),
    .op_err     (op_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [2:0] o, input logic [6:0] yy);
    op       = o;
    y        = yy;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_word();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_word"},      {24'd0, out_word},  32'd0);
    check({tag, "_ones"},      {28'd0, ones_count}, 32'd0);
    check({tag, "_err"},       {31'd0, op_err},    32'd0);
  endtask

  // y6 sequence 1,0,1,1,0,0,1,0 -> word 8'h4D
  logic [7:0] xor_bits = 8'b0100_1101;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; op = 3'd0; y = 7'd0; out_ready = 1'b0;

    // 1. reset with random inputs
    for (int i = 0; i < 2; i++) begin
      start     = 1'($urandom);
      in_valid  = 1'($urandom);
      op        = 3'($urandom);
      y         = 7'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_idle_zero("reset");

    // 2. XOR word, contiguous beats
    start_word();
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < WIDTH; i++) begin
      op = 3'd5; y = {1'b0, xor_bits[i], 5'd0}; in_valid = 1'b1;
      tick();
      if (i == 0) check("t2_bit0", {24'd0, out_word}, 32'h01);
    end
    // a ninth beat offered in HOLD must be ignored
    y = 7'h7F; in_valid = 1'b1;
    check("t2_out_valid", {31'd0, out_valid}, 32'd1);
    check("t2_in_ready_hold", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("t2_word", {24'd0, out_word}, 32'h4D);
    check("t2_ones", {28'd0, ones_count}, 32'd4);
    check("t2_err", {31'd0, op_err}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_consumed", {31'd0, out_valid}, 32'd0);
    check("t2_idle_busy", {31'd0, busy}, 32'd0);

    // 3. bubbles and backpressure
    start_word();
    for (int i = 0; i < WIDTH; i++) begin
      in_valid = 1'b0; y = 7'h7F;
      tick();
      op = 3'd5; y = {1'b0, xor_bits[i], 5'd0}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    check("t3_word", {24'd0, out_word}, 32'h4D);
    check("t3_ones", {28'd0, ones_count}, 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_consumed", {31'd0, out_valid}, 32'd0);

    // 4. illegal op on beat 3
    start_word();
    for (int i = 0; i < WIDTH; i++) send_beat((i == 3) ? 3'd7 : 3'd0, 7'h7F);
    check("t4_word", {24'd0, out_word}, 32'hF7);
    check("t4_ones", {28'd0, ones_count}, 32'd7);
    check("t4_err", {31'd0, op_err}, 32'd1);
    check("t4_busy_hold", {31'd0, busy}, 32'd0);

    // 5. back-to-back: handshake and start in the same HOLD cycle
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd1);
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_word_clr", {24'd0, out_word}, 32'd0);
    check("t5_ones_clr", {28'd0, ones_count}, 32'd0);
    check("t5_err_clr", {31'd0, op_err}, 32'd0);
    send_beat(3'd2, 7'h04);
    check("t5_bit0", {24'd0, out_word}, 32'h01);
    check("t5_ones1", {28'd0, ones_count}, 32'd1);
    for (int i = 0; i < 3; i++) send_beat(3'd2, 7'h00);

    // 6. reset after 4 beats, then a fresh full word
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("t6_reset");
    start_word();
    for (int i = 0; i < WIDTH; i++) send_beat(3'd1, 7'h02);
    check("t6_out_valid", {31'd0, out_valid}, 32'd1);
    check("t6_word", {24'd0, out_word}, 32'hFF);
    check("t6_ones", {28'd0, ones_count}, 32'd8);
    check("t6_err", {31'd0, op_err}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_consumed", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
